mux16_scan_sequencer: RTL and testbench

Upstream sequencer for the 16:1 input mux: drives the mux's 4-bit select, waits a programmable settle time per channel, samples the mux's 1-bit output, and assembles one 16-bit snapshot word per scan. Channels are enabled by a mask, and disabled channels are skipped without spending cycles. A start/busy/done handshake connects it to the consuming logic.

---
 rtl/mux16_scan_sequencer.sv | 143 ++++++++++++++
 tb/tb_mux16_scan_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mux16_scan_sequencer.sv
// Scan sequencer for a 16:1 mux: steps sel over the enabled channels in ascending
// order, holds each for SETTLE cycles, samples mux_out and publishes a 16-bit snapshot.
module mux16_scan_sequencer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] mask,
  input  logic        mux_out,
  output logic [3:0]  sel,
  output logic        busy,
  output logic        done,
  output logic [15:0] data,
  output logic [1:0]  o_state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  // Handshake: start is sampled only in IDLE; busy is high for the whole scan;
  // done is a single-cycle pulse in the cycle after data is written.

  state_t      r_state;
  logic [15:0] r_mask_q;
  logic [15:0] r_shadow;
  logic [3:0]  r_cnt;
  logic [3:0]  r_sel;
  logic [15:0] r_data;

  state_t      w_state_nxt;
  logic [15:0] w_mask_nxt;
  logic [15:0] w_shadow_nxt;
  logic [3:0]  w_cnt_nxt;
  logic [3:0]  w_sel_nxt;
  logic [15:0] w_data_nxt;

  logic [15:0] w_upto_sel;
  logic [15:0] w_above;
  logic        w_has_next;
  logic [3:0]  w_first_idx;
  logic [3:0]  w_next_idx;
  logic        w_settled;
  logic [15:0] w_sampled;

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // 2<<15 wraps to 0 in 16 bits, so the mask becomes all-ones at sel=15 and
  // no channel is left above it: sel can never wrap within a scan.
  assign w_upto_sel  = (16'd2 << r_sel) - 16'd1;
  assign w_above     = r_mask_q & ~w_upto_sel;
  assign w_has_next  = |w_above;
  assign w_first_idx = lowest_set(mask);
  assign w_next_idx  = lowest_set(w_above);
  assign w_settled   = (r_cnt == SETTLE_LAST);

  always_comb begin
    w_sampled        = r_shadow;
    w_sampled[r_sel] = mux_out;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_mask_nxt   = r_mask_q;
    w_shadow_nxt = r_shadow;
    w_cnt_nxt    = r_cnt;
    w_sel_nxt    = r_sel;
    w_data_nxt   = r_data;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_mask_nxt   = mask;
          w_shadow_nxt = 16'd0;
          w_cnt_nxt    = 4'd0;
          if (|mask) begin
            w_sel_nxt   = w_first_idx;
            w_state_nxt = S_SCAN;
          end else begin
            w_data_nxt  = 16'd0;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_SCAN: begin
        if (!w_settled) begin
          w_cnt_nxt = r_cnt + 4'd1;
        end else begin
          w_shadow_nxt = w_sampled;
          if (w_has_next) begin
            w_sel_nxt = w_next_idx;
            w_cnt_nxt = 4'd0;
          end else begin
            w_data_nxt  = w_sampled;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mask_q <= 16'd0;
      r_shadow <= 16'd0;
      r_cnt    <= 4'd0;
      r_sel    <= 4'd0;
      r_data   <= 16'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_mask_q <= w_mask_nxt;
      r_shadow <= w_shadow_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sel    <= w_sel_nxt;
      r_data   <= w_data_nxt;
    end
  end

  assign sel         = r_sel;
  assign busy        = (r_state == S_SCAN);
  assign done        = (r_state == S_DONE);
  assign data        = r_data;
  assign o_state_dbg = r_state;

endmodule

// File: tb/tb_mux16_scan_sequencer.sv
// Bench for mux16_scan_sequencer: three instances (SETTLE=1,2,3) driven by directed
// and random scans, checked against a channel-list reference model.
module tb_mux16_scan_sequencer;

  logic        clk;
  logic        rst;
  logic        start_a [3];
  logic [15:0] mask_a  [3];
  logic [15:0] pat_a   [3];
  logic        mux_a   [3];
  logic [3:0]  sel_a   [3];
  logic        busy_a  [3];
  logic        done_a  [3];
  logic [15:0] data_a  [3];
  logic [1:0]  st_a    [3];

  int checks;
  int failures;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mux16_scan_sequencer #(.SETTLE(g + 1)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start_a[g]),
      .mask       (mask_a[g]),
      .mux_out    (mux_a[g]),
      .sel        (sel_a[g]),
      .busy       (busy_a[g]),
      .done       (done_a[g]),
      .data       (data_a[g]),
      .o_state_dbg(st_a[g])
    );
    // Combinational 16:1 mux model: the input pattern indexed by sel.
    assign mux_a[g] = pat_a[g][sel_a[g]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_all(input string tag, input logic [15:0] exp_data);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_s%0d_busy", tag, k + 1), 32'(busy_a[k]), 32'd0);
      chk($sformatf("%s_s%0d_done", tag, k + 1), 32'(done_a[k]), 32'd0);
      chk($sformatf("%s_s%0d_sel", tag, k + 1), 32'(sel_a[k]), 32'd0);
      chk($sformatf("%s_s%0d_data", tag, k + 1), 32'(data_a[k]), 32'(exp_data));
    end
  endtask

  // One scan on instance k. Expected per-cycle sel list: each enabled channel in
  // ascending order, repeated SETTLE times; the result is the pattern under the mask.
  task automatic run_scan(input int k, input logic [15:0] m, input logic [15:0] p,
                          input int pulse_at, input string tag);
    int s;
    int exp_sel[$];
    s = k + 1;
    for (int ch = 0; ch < 16; ch++)
      if (m[ch]) for (int r = 0; r < s; r++) exp_sel.push_back(ch);
    @(negedge clk);
    pat_a[k]   = p;
    mask_a[k]  = m;
    start_a[k] = 1'b1;
    @(negedge clk);
    start_a[k] = 1'b0;
    mask_a[k]  = 16'($urandom);
    for (int j = 0; j < exp_sel.size(); j++) begin
      if (j > 0) @(negedge clk);
      chk($sformatf("%s_busy_c%0d", tag, j), 32'(busy_a[k]), 32'd1);
      chk($sformatf("%s_sel_c%0d", tag, j), 32'(sel_a[k]), 32'(exp_sel[j]));
      chk($sformatf("%s_done_c%0d", tag, j), 32'(done_a[k]), 32'd0);
      if (j == pulse_at) begin
        start_a[k] = 1'b1;
        mask_a[k]  = 16'h0001;
      end else begin
        start_a[k] = 1'b0;
      end
    end
    if (exp_sel.size() > 0) @(negedge clk);
    start_a[k] = 1'b0;
    chk($sformatf("%s_done", tag), 32'(done_a[k]), 32'd1);
    chk($sformatf("%s_busy_at_done", tag), 32'(busy_a[k]), 32'd0);
    chk($sformatf("%s_data", tag), 32'(data_a[k]), 32'(m & p));
    @(negedge clk);
    chk($sformatf("%s_done_after", tag), 32'(done_a[k]), 32'd0);
    chk($sformatf("%s_busy_after", tag), 32'(busy_a[k]), 32'd0);
    chk($sformatf("%s_data_hold", tag), 32'(data_a[k]), 32'(m & p));
    if (exp_sel.size() > 0)
      chk($sformatf("%s_sel_hold", tag), 32'(sel_a[k]), 32'(exp_sel[exp_sel.size() - 1]));
  endtask

  initial begin
    logic [15:0] p;
    logic [15:0] m;
    int k;
    int phase;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_a[i] = 1'b0;
      mask_a[i]  = 16'd0;
      pat_a[i]   = 16'd0;
    end

    // Reset then idle
    repeat (2) @(negedge clk);
    chk_idle_all("reset", 16'h0000);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk_idle_all("idle", 16'h0000);

    // Full scan, sparse scan, empty mask, start-while-busy
    run_scan(1, 16'hFFFF, 16'hA5C3, -1, "full_s2");
    run_scan(0, 16'h8011, 16'hFFFF, -1, "sparse_s1");
    run_scan(1, 16'h0000, 16'($urandom), -1, "mask0_s2");
    run_scan(1, 16'h00F0, 16'($urandom), 3, "startbusy_s2");

    // Reset at the 5th busy cycle of a full scan
    @(negedge clk);
    pat_a[1] = 16'($urandom); mask_a[1] = 16'hFFFF; start_a[1] = 1'b1;
    @(negedge clk);
    start_a[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_busy_before", 32'(busy_a[1]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_all("midrst", 16'h0000);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk($sformatf("midrst_nodone_%0d", i), 32'(done_a[1]), 32'd0);
    end
    run_scan(1, 16'hFFFF, 16'h3C5A, -1, "after_rst_s2");

    // Back-to-back with start held, SETTLE=3, mask=0x0003: period 8
    @(negedge clk);
    p = 16'($urandom);
    pat_a[2] = p; mask_a[2] = 16'h0003; start_a[2] = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      phase = c % 8;
      chk($sformatf("b2b_busy_c%0d", c), 32'(busy_a[2]), 32'((phase >= 1) && (phase <= 6)));
      chk($sformatf("b2b_done_c%0d", c), 32'(done_a[2]), 32'(phase == 7));
      if (phase >= 1 && phase <= 6)
        chk($sformatf("b2b_sel_c%0d", c), 32'(sel_a[2]), 32'(phase >= 4));
      if (phase == 7) begin
        chk($sformatf("b2b_data_c%0d", c), 32'(data_a[2]), 32'(p & 16'h0003));
        p = 16'($urandom);
        pat_a[2] = p;
      end
      if (c == 24) start_a[2] = 1'b0;
    end
    repeat (3) begin
      @(negedge clk);
      chk("b2b_stopped", 32'(busy_a[2]), 32'd0);
    end

    // Random scans across all three settle values
    for (int i = 0; i < 15; i++) begin
      k = $urandom_range(0, 2);
      m = 16'($urandom);
      if (i % 4 == 0) m = m & 16'($urandom) & 16'($urandom);
      if (i == 7) m = 16'h0000;
      run_scan(k, m, 16'($urandom), (i % 3 == 0) ? 1 : -1, $sformatf("rnd%0d_s%0d", i, k + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
